tqvp_utf8_stream_decoder: RTL

- Streaming UTF-8 to code-point decoder peripheral on the TinyQV register bus.
- Buffers incoming bytes in a parametrised input FIFO and decodes them with a byte-per-cycle FSM.
- Pushes 21-bit code points plus error flags into a parametrised output FIFO.
- Malformed input is replaced with U+FFFD. Unlike the single-character transcoder, it handles back-to-back characters without software re-arming per character.

---
 rtl/utf8_stream_pkg.sv | 45 ++++
 rtl/utf8_sync_fifo.sv | 57 +++++
 rtl/tqvp_utf8_stream_decoder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/utf8_stream_pkg.sv
// Shared constants and types for the TinyQV streaming UTF-8 decoder.
// Register map, status/flag bit positions and the decoder state enum.
package utf8_stream_pkg;

  localparam logic [3:0] ADDR_CTRL    = 4'd0;
  localparam logic [3:0] ADDR_DATA    = 4'd1;
  localparam logic [3:0] ADDR_POP     = 4'd2;

  localparam logic [3:0] ADDR_STATUS  = 4'd0;
  localparam logic [3:0] ADDR_IN_CNT  = 4'd1;
  localparam logic [3:0] ADDR_OUT_CNT = 4'd2;
  localparam logic [3:0] ADDR_FLAGS   = 4'd3;
  localparam logic [3:0] ADDR_CP0     = 4'd4;
  localparam logic [3:0] ADDR_CP1     = 4'd5;
  localparam logic [3:0] ADDR_CP2     = 4'd6;

  localparam int ST_DROP      = 0;
  localparam int ST_UNF       = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_BUSY      = 3;
  localparam int ST_OUT_EMPTY = 4;
  localparam int ST_OUT_FULL  = 5;
  localparam int ST_IN_EMPTY  = 6;
  localparam int ST_IN_FULL   = 7;

  localparam int FL_RANGE    = 0;
  localparam int FL_SURR     = 1;
  localparam int FL_OVERLONG = 2;
  localparam int FL_INVALID  = 3;
  localparam int FL_TRUNC    = 4;

  localparam int FLAG_W = 5;
  localparam int CP_W   = 21;
  localparam int ENT_W  = FLAG_W + CP_W;

  localparam logic [20:0] REPLACEMENT_CP = 21'h00FFFD;
  localparam logic [20:0] MAX_CP         = 21'h10FFFF;
  localparam logic [20:0] BOM_CP         = 21'h00FEFF;

  typedef enum logic {
    S_IDLE,
    S_CONT
  } state_t;

endpackage

// File: rtl/utf8_sync_fifo.sv
// Single-clock FIFO with flush; push when full and pop when empty
// are ignored, so callers keep their own overflow bookkeeping.
module utf8_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tqvp_utf8_stream_decoder.sv
// Streaming UTF-8 decoder peripheral: byte FIFO -> decode FSM -> cp FIFO.
// Define UTF8_BOM_STRIP_EN to drop a leading U+FEFF after reset/flush.
module tqvp_utf8_stream_decoder #(
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  import utf8_stream_pkg::*;

  localparam int IW = $clog2(IN_DEPTH) + 1;
  localparam int OW = $clog2(OUT_DEPTH) + 1;

  logic             wr_ctrl, flush, bus_push, bus_pop;
  logic             in_full, in_empty, out_full, out_empty;
  logic [IW-1:0]    in_cnt;
  logic [OW-1:0]    out_cnt;
  logic [7:0]       b;
  logic [ENT_W-1:0] out_head, h_ent;
  logic             drop_err, ovf, unf, busy;
  logic             unused_ok;

  state_t      state, nx_state;
  logic [1:0]  need, nx_need;
  logic [14:0] acc, nx_acc;
  logic [20:0] min_cp, nx_min, full_cp, e_cp;
  logic [4:0]  e_flags;
  logic        emit, consume, err, bom_drop, keep;
  logic        dec_valid, go, in_pop, out_push;

  assign unused_ok = &{1'b0, ui_in};
  assign uo_out    = 8'h00;

  assign wr_ctrl  = data_write && address == ADDR_CTRL;
  assign flush    = wr_ctrl && data_in[0];
  assign bus_push = data_write && address == ADDR_DATA;
  assign bus_pop  = data_write && address == ADDR_POP;

  utf8_sync_fifo #(.WIDTH(8), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (bus_push),
    .pop   (in_pop),
    .din   (data_in),
    .head  (b),
    .full  (in_full),
    .empty (in_empty),
    .count (in_cnt)
  );

  utf8_sync_fifo #(.WIDTH(ENT_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (out_push),
    .pop   (bus_pop),
    .din   ({e_flags, e_cp}),
    .head  (out_head),
    .full  (out_full),
    .empty (out_empty),
    .count (out_cnt)
  );

  assign full_cp = {acc, b[5:0]};

  always_comb begin
    nx_state = state;
    nx_need  = need;
    nx_acc   = acc;
    nx_min   = min_cp;
    emit     = 1'b0;
    consume  = 1'b0;
    e_cp     = REPLACEMENT_CP;
    e_flags  = '0;
    if (state == S_IDLE) begin
      consume = 1'b1;
      unique case (1'b1)
        !b[7]: begin
          emit = 1'b1;
          e_cp = {13'd0, b};
        end
        (b >= 8'hC2 && b <= 8'hDF): begin
          nx_state = S_CONT;
          nx_need  = 2'd1;
          nx_acc   = {10'd0, b[4:0]};
          nx_min   = 21'h000080;
        end
        (b[7:4] == 4'hE): begin
          nx_state = S_CONT;
          nx_need  = 2'd2;
          nx_acc   = {11'd0, b[3:0]};
          nx_min   = 21'h000800;
        end
        (b >= 8'hF0 && b <= 8'hF4): begin
          nx_state = S_CONT;
          nx_need  = 2'd3;
          nx_acc   = {12'd0, b[2:0]};
          nx_min   = 21'h010000;
        end
        default: begin
          emit = 1'b1;
          e_flags[FL_INVALID] = 1'b1;
        end
      endcase
    end else if (b[7:6] == 2'b10) begin
      consume = 1'b1;
      nx_acc  = full_cp[14:0];
      nx_need = need - 2'd1;
      if (need == 2'd1) begin
        nx_state = S_IDLE;
        emit     = 1'b1;
        if (full_cp < min_cp)
          e_flags[FL_OVERLONG] = 1'b1;
        else if (full_cp >= 21'h00D800 && full_cp <= 21'h00DFFF)
          e_flags[FL_SURR] = 1'b1;
        else if (full_cp > MAX_CP)
          e_flags[FL_RANGE] = 1'b1;
        else
          e_cp = full_cp;
      end
    end else begin
      // Broken sequence: the offending byte stays queued for a fresh look
      nx_state = S_IDLE;
      emit     = 1'b1;
      e_flags[FL_TRUNC] = 1'b1;
    end
  end

`ifdef UTF8_BOM_STRIP_EN
  logic seen;
  assign bom_drop = emit && !err && !seen && e_cp == BOM_CP;
`else
  assign bom_drop = 1'b0;
`endif

  assign err       = |e_flags;
  assign keep      = emit && !(err && drop_err) && !bom_drop;
  assign dec_valid = !in_empty && !flush;
  assign go        = dec_valid && !(keep && out_full);
  assign in_pop    = go && consume;
  assign out_push  = go && keep;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      need     <= '0;
      acc      <= '0;
      min_cp   <= '0;
      drop_err <= 1'b0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
`ifdef UTF8_BOM_STRIP_EN
      seen     <= 1'b0;
`endif
    end else begin
      if (wr_ctrl) drop_err <= data_in[1];
      if (flush) begin
        state  <= S_IDLE;
        need   <= '0;
        acc    <= '0;
        min_cp <= '0;
        ovf    <= 1'b0;
        unf    <= 1'b0;
`ifdef UTF8_BOM_STRIP_EN
        seen   <= 1'b0;
`endif
      end else begin
        if (bus_push && in_full) ovf <= 1'b1;
        if (bus_pop && out_empty) unf <= 1'b1;
        if (go) begin
          state  <= nx_state;
          need   <= nx_need;
          acc    <= nx_acc;
          min_cp <= nx_min;
`ifdef UTF8_BOM_STRIP_EN
          if (emit && !err) seen <= 1'b1;
`endif
        end
      end
    end
  end

  assign busy  = (state == S_CONT) || !in_empty;
  assign h_ent = out_empty ? '0 : out_head;

  always_comb begin
    data_out = 8'h00;
    case (address)
      ADDR_STATUS:  data_out = {in_full, in_empty, out_full, out_empty,
                                busy, ovf, unf, drop_err};
      ADDR_IN_CNT:  data_out = 8'(in_cnt);
      ADDR_OUT_CNT: data_out = 8'(out_cnt);
      ADDR_FLAGS:   data_out = {3'b000, h_ent[25:21]};
      ADDR_CP0:     data_out = h_ent[7:0];
      ADDR_CP1:     data_out = h_ent[15:8];
      ADDR_CP2:     data_out = {3'b000, h_ent[20:16]};
      default:      data_out = 8'h00;
    endcase
  end

endmodule
